// File: rtl/drac_pkg.sv
// Core-wide configuration constants shared by the L1.5 interface blocks.
package drac_pkg;

   // Default number of request-queue entries in front of the L1.5.
   localparam int unsigned L15_REQ_QUEUE_DEPTH = 32'd4;
   // Default cap on requests acknowledged by the L1.5 but not yet answered.
   localparam int unsigned L15_MAX_OUTSTANDING = 32'd8;

endpackage

// File: rtl/wt_cache_pkg.sv
// Request and return structures of the core <-> L1.5 interface.
package wt_cache_pkg;

   typedef struct packed {
      logic        l15_val;
      logic [4:0]  l15_rqtype;
      logic        l15_nc;
      logic [2:0]  l15_size;
      logic [39:0] l15_address;
      logic [63:0] l15_data;
   } l15_req_t;

   typedef struct packed {
      logic        l15_val;
      logic [3:0]  l15_returntype;
      logic        l15_header_ack;
      logic [63:0] l15_data_0;
   } l15_rtrn_t;

endpackage

// File: rtl/lagarto_l15_fifo.sv
// Generic struct FIFO: registered pointers/count, unreset storage, head always visible.
module lagarto_l15_fifo #(
   parameter int unsigned DEPTH = 32'd4,
   parameter type         T     = logic
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  T                         data_i,
   input  logic                     pop_i,
   output T                         head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   T                mem_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [PW:0]     count_r;
   logic            push_ok_s;
   logic            pop_ok_s;

   assign full_o    = (count_r == (PW+1)'(DEPTH));
   assign empty_o   = (count_r == (PW+1)'(0));
   assign push_ok_s = push_i && !full_o;
   assign pop_ok_s  = pop_i && !empty_o;
   assign head_o    = mem_r[rd_ptr_r];
   assign count_o   = count_r;

   // Entry storage: written on accepted push only, no reset needed.
   always_ff @(posedge clk_i) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= data_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
      end
   end

   // Occupancy: simultaneous push and pop leave it unchanged.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_r <= '0;
      end else begin
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/lagarto_l15_req_queue.sv
// Core-to-L1.5 request queue with outstanding-request credit cap and sticky protocol error.
module lagarto_l15_req_queue
   import drac_pkg::*;
   import wt_cache_pkg::*;
#(
   parameter int unsigned DEPTH           = L15_REQ_QUEUE_DEPTH,
   parameter int unsigned MAX_OUTSTANDING = L15_MAX_OUTSTANDING
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  l15_req_t                 core_req_i,
   output logic                     core_ready_o,
   output l15_req_t                 l15_req_o,
   input  l15_rtrn_t                l15_rtrn_i,
   input  logic                     resp_done_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [7:0]               outstanding_o,
   output logic                     err_o
);

   l15_req_t                 head_s;
   logic [$clog2(DEPTH):0]   count_s;
   logic                     full_s;
   logic                     empty_s;
   logic                     push_s;
   logic                     pop_s;
   logic                     issue_s;
   logic                     ack_s;
   logic                     err_hit_s;
   logic [7:0]               outstanding_r;
   logic [7:0]               outstanding_nxt_s;
   logic                     err_r;
   logic                     unused_rtrn_s;

   // Only the header ack of the return channel matters here.
   assign ack_s         = l15_rtrn_i.l15_header_ack;
   assign unused_rtrn_s = ^{l15_rtrn_i.l15_val, l15_rtrn_i.l15_returntype,
                            l15_rtrn_i.l15_data_0, head_s.l15_val};

   // Ready and issue depend only on registered state (no bypass, no pop-to-push forwarding).
   assign core_ready_o  = !full_s;
   assign push_s        = core_req_i.l15_val && !full_s;
   assign issue_s       = !empty_s && (outstanding_r < 8'(MAX_OUTSTANDING));
   assign pop_s         = issue_s && ack_s;
   assign err_hit_s     = (ack_s && !issue_s) || (resp_done_i && (outstanding_r == 8'd0));

   assign count_o       = count_s;
   assign outstanding_o = outstanding_r;
   assign err_o         = err_r;

   lagarto_l15_fifo #(
      .DEPTH (DEPTH),
      .T     (l15_req_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push_s),
      .data_i  (core_req_i),
      .pop_i   (pop_s),
      .head_o  (head_s),
      .count_o (count_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   // Present the head entry; valid is gated by occupancy and credits.
   always_comb begin
      l15_req_o         = head_s;
      l15_req_o.l15_val = issue_s;
   end

   // Credit counter next value: +1 on issue pop, -1 on response, never below zero.
   always_comb begin
      outstanding_nxt_s = outstanding_r;
      case ({pop_s, resp_done_i})
         2'b10: outstanding_nxt_s = outstanding_r + 8'd1;
         2'b01: begin
            if (outstanding_r != 8'd0) begin
               outstanding_nxt_s = outstanding_r - 8'd1;
            end else begin
               outstanding_nxt_s = outstanding_r;
            end
         end
         default: outstanding_nxt_s = outstanding_r;
      endcase
   end

   // Credit counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_r <= 8'd0;
      end else begin
         outstanding_r <= outstanding_nxt_s;
      end
   end

   // Sticky error: spurious header ack or response with nothing in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_r <= 1'b0;
      end else if (err_hit_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

endmodule

// File: tb/tb_lagarto_l15_req_queue.sv
// Scoreboard bench for lagarto_l15_req_queue (DEPTH=4, MAX_OUTSTANDING=2).
module tb_lagarto_l15_req_queue;
   import wt_cache_pkg::*;

   localparam int DEPTH = 4;
   localparam int MAXO  = 2;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   l15_req_t   core_req;
   logic       core_ready;
   l15_req_t   l15_req;
   l15_rtrn_t  rtrn;
   logic       resp_done;
   logic [2:0] count;
   logic [7:0] outstanding;
   logic       err;

   int total = 0;
   int bad   = 0;

   // Reference model state: occupancy, credits, sticky error, expected issue order.
   int        count_m = 0;
   int        out_m   = 0;
   bit        err_m   = 1'b0;
   bit        mon_en  = 1'b0;
   l15_req_t  exp_q[$];

   lagarto_l15_req_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .core_req_i    (core_req),
      .core_ready_o  (core_ready),
      .l15_req_o     (l15_req),
      .l15_rtrn_i    (rtrn),
      .resp_done_i   (resp_done),
      .count_o       (count),
      .outstanding_o (outstanding),
      .err_o         (err)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic l15_req_t rand_req();
      l15_req_t r;
      r.l15_val     = 1'b1;
      r.l15_rqtype  = 5'($urandom);
      r.l15_nc      = 1'($urandom);
      r.l15_size    = 3'($urandom);
      r.l15_address = {8'($urandom), 32'($urandom)};
      r.l15_data    = {32'($urandom), 32'($urandom)};
      return r;
   endfunction

   function automatic bit model_val();
      return (count_m != 0) && (out_m < MAXO);
   endfunction

   // One clock cycle with raw inputs; the model advances at the rising edge.
   task automatic cyc(input bit v, input bit a, input bit r);
      l15_req_t q;
      bit mv, do_push, do_pop;
      q = rand_req();
      q.l15_val = v;
      core_req = q;
      rtrn = '0;
      rtrn.l15_header_ack = a;
      resp_done = r;
      mv      = model_val();
      do_push = v && (count_m != DEPTH);
      do_pop  = mv && a;
      @(posedge clk_i);
      if (a && !mv) err_m = 1'b1;
      if (r && out_m == 0) err_m = 1'b1;
      if (do_push) exp_q.push_back(q);
      count_m = count_m + int'(do_push) - int'(do_pop);
      if (do_pop && r) out_m = out_m;
      else if (do_pop) out_m = out_m + 1;
      else if (r && out_m > 0) out_m = out_m - 1;
      #1;
   endtask

   // Protocol-legal cycle: ack only when a request is offered, response only when one is in flight.
   task automatic cyc_ok(input bit v, input bit a, input bit r);
      cyc(v, a && model_val(), r && (out_m > 0));
   endtask

   task automatic reset_mid();
      #2 rst_ni = 1'b0;
      #1;
      chk("rst_count", count, 3'd0);
      chk("rst_ready", core_ready, 1'b1);
      chk("rst_l15_val", l15_req.l15_val, 1'b0);
      chk("rst_outstanding", outstanding, 8'd0);
      chk("rst_err", err, 1'b0);
      count_m = 0; out_m = 0; err_m = 1'b0;
      exp_q.delete();
      core_req = '0; rtrn = '0; resp_done = 1'b0;
      @(posedge clk_i);
      #2 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   // Monitor: compares state every cycle and checks each offered request against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk_i);
         if (rst_ni && mon_en) begin
            chk("count", count, 128'(count_m));
            chk("ready", core_ready, 128'(count_m != DEPTH));
            chk("l15_val", l15_req.l15_val, 128'(model_val()));
            chk("outstanding", outstanding, 128'(out_m));
            chk("err", err, 128'(err_m));
            if (l15_req.l15_val) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL scoreboard_empty at %0t: request offered, none expected", $time);
               end else begin
                  chk("payload", l15_req, exp_q[0]);
                  if (rtrn.l15_header_ack) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      core_req = '0; rtrn = '0; resp_done = 1'b0;
      #12 rst_ni = 1'b1;
      @(posedge clk_i); #1;
      mon_en = 1'b1;
      chk("init_count", count, 3'd0);
      chk("init_ready", core_ready, 1'b1);

      // Single request: enqueue, ack three cycles later, then respond.
      cyc_ok(1, 0, 0); cyc_ok(0, 0, 0); cyc_ok(0, 0, 0); cyc_ok(0, 1, 0);
      cyc_ok(0, 0, 0);
      chk("single_out", outstanding, 8'd1);
      cyc_ok(0, 0, 1); cyc_ok(0, 0, 0);

      // Fill to full, offer a fifth, then drain in order with responses.
      repeat (5) cyc_ok(1, 0, 0);
      chk("full_count", count, 3'd4);
      chk("full_ready", core_ready, 1'b0);
      repeat (8) cyc_ok(0, 1, 1);
      repeat (3) cyc_ok(0, 0, 1);

      // Credit cap: three requests with immediate acks, only two issue until a response.
      repeat (3) cyc_ok(1, 1, 0);
      repeat (3) cyc_ok(0, 1, 0);
      chk("cap_out", outstanding, 8'd2);
      chk("cap_val", l15_req.l15_val, 1'b0);
      cyc_ok(0, 0, 1);
      chk("cap_reissue", l15_req.l15_val, 1'b1);
      cyc_ok(0, 1, 0);
      repeat (3) cyc_ok(0, 0, 1);

      // Simultaneous enqueue+pop and pop+response, then pointer wrap over 9 enqueues.
      cyc_ok(1, 0, 0);
      cyc_ok(1, 1, 0);
      cyc_ok(0, 1, 1);
      repeat (9) cyc_ok(1, 1, 1);
      repeat (6) cyc_ok(0, 1, 1);

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         cyc_ok($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
      end
      repeat (12) cyc_ok(0, 1, 1);

      // Reset with 3 queued and 2 outstanding; nothing issues afterwards until a new enqueue.
      reset_mid();
      repeat (4) cyc_ok(1, 0, 0);
      cyc_ok(0, 1, 0); cyc_ok(0, 1, 0); cyc_ok(1, 0, 0);
      chk("pre_rst_count", count, 3'd3);
      chk("pre_rst_out", outstanding, 8'd2);
      reset_mid();
      repeat (3) cyc_ok(0, 1, 0);
      cyc_ok(1, 0, 0); cyc_ok(0, 1, 0); cyc_ok(0, 0, 1);

      // Errors: response with nothing in flight, then spurious ack; both sticky.
      cyc(0, 0, 1);
      chk("err_resp_out", outstanding, 8'd0);
      chk("err_resp", err, 1'b1);
      repeat (3) cyc_ok(1, 1, 1);
      chk("err_sticky", err, 1'b1);
      reset_mid();
      cyc(0, 1, 0);
      chk("err_ack", err, 1'b1);
      repeat (2) cyc_ok(0, 0, 0);
      reset_mid();
      cyc_ok(0, 0, 0);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

endmodule
